regfile_mp: RTL and testbench

- Parametrised multi-read-port integer register file; successor to the single-write, two-read 64-bit file in the decode stage.
- Adds configurable width, depth and read-port count.
- Adds a hardwired zero register, write-to-read bypass and posedge-registered reads.
- Adds a hardware clear sequencer that zeroes all registers after reset or on request, with a busy indication for the pipeline stall logic.

---
 rtl/regfile_pkg.sv | 24 ++
 rtl/regfile_clear_fsm.sv | 71 +++++++
 rtl/regfile_mp.sv | 125 ++++++++++++
 tb/tb_regfile_mp.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-read-port register file.
// Used by regfile_clear_fsm and regfile_mp (optional parity: REGFILE_PARITY_EN).
package regfile_pkg;

    // CLEAR zeroes entries 1..NREG-1 one per cycle; READY is normal operation.
    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    localparam int XLEN_DEFAULT = 64;
    localparam int NREG_DEFAULT = 32;

    // Widest data word even_parity accepts. Narrower words are zero-extended,
    // which leaves the parity unchanged.
    localparam int PARITY_MAX_W = 256;

    // Even-parity bit: set when the word holds an odd number of ones, so
    // word plus parity bit always carries an even count.
    function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear sequencer: after reset or a clear request, walks idx from 1 to
// NREG-1 writing zero to each entry, and holds busy high while doing so.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int  NREG = NREG_DEFAULT,
    localparam int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear_req,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr,
    output logic          ready
);

    localparam logic [AW-1:0] IDX_FIRST = AW'(1);
    localparam logic [AW-1:0] IDX_LAST  = AW'(NREG - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          busy_q, busy_d;

    // Next-state: advance idx while clearing, stop at the last entry without wrapping.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            CLEAR: begin
                if (clear_req) begin
                    idx_d = IDX_FIRST;
                end else if (idx_q == IDX_LAST) begin
                    state_d = READY;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            READY: begin
                if (clear_req) begin
                    state_d = CLEAR;
                    idx_d   = IDX_FIRST;
                end
            end
            default: begin
                state_d = CLEAR;
                idx_d   = IDX_FIRST;
            end
        endcase
        busy_d = (state_d == CLEAR);
    end

    // State, index and busy registers; reset restarts the clear sequence.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= CLEAR;
            idx_q   <= IDX_FIRST;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
        end
    end

    assign busy     = busy_q;
    assign clr_we   = (state_q == CLEAR);
    assign clr_addr = idx_q;
    assign ready    = (state_q == READY);

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with hardwired x0, write-first bypass,
// registered reads and a hardware clear sequencer.
// Optional feature macro: REGFILE_PARITY_EN adds per-entry even parity and par_err.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int  XLEN = XLEN_DEFAULT,
    parameter int  NREG = NREG_DEFAULT,
    parameter int  NRD  = 2,
    localparam int AW   = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear_req,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [XLEN-1:0]     wdata,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
`ifdef REGFILE_PARITY_EN
    output logic [NRD-1:0]      par_err,
`endif
    output logic                busy,
    output logic                wr_drop
);

    logic          clr_we;
    logic [AW-1:0] clr_addr;
    logic          ready;

    regfile_clear_fsm #(.NREG(NREG)) u_clear_fsm (
        .clk       (clk),
        .reset     (reset),
        .clear_req (clear_req),
        .busy      (busy),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr),
        .ready     (ready)
    );

    // Entry 0 is never written; reads of address 0 are forced to zero.
    logic [XLEN-1:0]     mem_q [NREG];
    logic                wr_commit;
    logic                mem_we;
    logic [AW-1:0]       mem_waddr;
    logic [XLEN-1:0]     mem_wdata;
    logic [AW-1:0]       ra [NRD];
    logic                rd_zero;
    logic [NRD*XLEN-1:0] rdata_d, rdata_q;
    logic                wr_drop_d, wr_drop_q;
`ifdef REGFILE_PARITY_EN
    logic                par_mem_q [NREG];
    logic                par_wbit;
    logic [NRD-1:0]      par_err_d, par_err_q;
`endif

    // Write port arbitration: the clear sequencer owns the port while not ready.
    always_comb begin
        wr_commit = we && ready && !clear_req && (waddr != '0);
        wr_drop_d = we && (!ready || clear_req);
        // Storage is frozen while reset is asserted.
        mem_we    = reset && (clr_we || wr_commit);
        mem_waddr = clr_we ? clr_addr : waddr;
        mem_wdata = clr_we ? '0 : wdata;
`ifdef REGFILE_PARITY_EN
        par_wbit  = clr_we ? 1'b0 : even_parity(PARITY_MAX_W'(wdata));
`endif
    end

    // Storage array (no reset: contents survive reset and are zeroed by the sequencer).
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
`ifdef REGFILE_PARITY_EN
            par_mem_q[mem_waddr] <= par_wbit;
`endif
        end
    end

    // Read ports: clear forces zero, then x0, then write-first bypass, then storage.
    always_comb begin
        rdata_d = '0;
        rd_zero = !ready || clear_req;
`ifdef REGFILE_PARITY_EN
        par_err_d = '0;
`endif
        for (int i = 0; i < NRD; i++) begin
            ra[i] = raddr[i*AW +: AW];
            if (rd_zero || (ra[i] == '0)) begin
                rdata_d[i*XLEN +: XLEN] = '0;
            end else if (wr_commit && (waddr == ra[i])) begin
                rdata_d[i*XLEN +: XLEN] = wdata;
            end else begin
                rdata_d[i*XLEN +: XLEN] = mem_q[ra[i]];
`ifdef REGFILE_PARITY_EN
                par_err_d[i] = par_mem_q[ra[i]] != even_parity(PARITY_MAX_W'(mem_q[ra[i]]));
`endif
            end
        end
    end

    // Registered read data and status pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata_q   <= '0;
            wr_drop_q <= 1'b0;
`ifdef REGFILE_PARITY_EN
            par_err_q <= '0;
`endif
        end else begin
            rdata_q   <= rdata_d;
            wr_drop_q <= wr_drop_d;
`ifdef REGFILE_PARITY_EN
            par_err_q <= par_err_d;
`endif
        end
    end

    assign rdata   = rdata_q;
    assign wr_drop = wr_drop_q;
`ifdef REGFILE_PARITY_EN
    assign par_err = par_err_q;
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: a register-array model with a clear
// countdown predicts outputs every cycle; directed vectors add literal checks.
module tb_regfile_mp;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int AW   = 5;

    logic                clk = 1'b0;
    logic                reset;
    logic                clear_req;
    logic                we;
    logic [AW-1:0]       waddr;
    logic [XLEN-1:0]     wdata;
    logic [NRD*AW-1:0]   raddr;
    logic [NRD*XLEN-1:0] rdata;
    logic                busy;
    logic                wr_drop;
`ifdef REGFILE_PARITY_EN
    logic [NRD-1:0]      par_err;
`endif

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
        .clk       (clk),
        .reset     (reset),
        .clear_req (clear_req),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .raddr     (raddr),
        .rdata     (rdata),
`ifdef REGFILE_PARITY_EN
        .par_err   (par_err),
`endif
        .busy      (busy),
        .wr_drop   (wr_drop)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [XLEN-1:0] rd(input int p);
        return rdata[p*XLEN +: XLEN];
    endfunction

    task automatic set_rd(input int p, input int a);
        raddr[p*AW +: AW] = AW'(a);
    endtask

    // ---------------- behavioural model ----------------
    logic [XLEN-1:0] m_reg [NREG];
    int              clear_cnt;     // entries still to be zeroed; >0 means busy
    logic [XLEN-1:0] exp_rd [NRD];
    logic            exp_busy;
    logic            exp_drop;
    bit              chk_en = 1'b0;
`ifdef REGFILE_PARITY_EN
    bit              m_bad [NREG];  // entry holds data whose parity no longer matches
    logic [NRD-1:0]  exp_par;
`endif

    initial begin
        for (int r = 0; r < NREG; r++) m_reg[r] = '0;
`ifdef REGFILE_PARITY_EN
        for (int r = 0; r < NREG; r++) m_bad[r] = 1'b0;
`endif
    end

    always @(posedge clk) begin : model
        bit clearing;
        bit commit;
        int ra;
        int wa;
        if (!reset) begin
            clear_cnt = NREG - 1;
            exp_busy  = 1'b1;
            exp_drop  = 1'b0;
            for (int i = 0; i < NRD; i++) exp_rd[i] = '0;
`ifdef REGFILE_PARITY_EN
            exp_par = '0;
`endif
        end else begin
            clearing = (clear_cnt > 0);
            wa       = int'(waddr);
            commit   = we && !clearing && !clear_req && (wa != 0);
            for (int i = 0; i < NRD; i++) begin
                ra = int'(raddr[i*AW +: AW]);
`ifdef REGFILE_PARITY_EN
                exp_par[i] = 1'b0;
`endif
                if (clearing || clear_req || ra == 0) begin
                    exp_rd[i] = '0;
                end else if (commit && wa == ra) begin
                    exp_rd[i] = wdata;
                end else begin
                    exp_rd[i] = m_reg[ra];
`ifdef REGFILE_PARITY_EN
                    exp_par[i] = m_bad[ra];
`endif
                end
            end
            exp_drop = we && (clearing || clear_req);
            if (clearing) begin
                m_reg[NREG - clear_cnt] = '0;
`ifdef REGFILE_PARITY_EN
                m_bad[NREG - clear_cnt] = 1'b0;
`endif
            end
            if (commit) begin
                m_reg[wa] = wdata;
`ifdef REGFILE_PARITY_EN
                m_bad[wa] = 1'b0;
`endif
            end
            if (clear_req) clear_cnt = NREG - 1;
            else if (clearing) clear_cnt = clear_cnt - 1;
            exp_busy = (clear_cnt > 0);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", XLEN'(busy), XLEN'(exp_busy));
            check("wr_drop", XLEN'(wr_drop), XLEN'(exp_drop));
            for (int i = 0; i < NRD; i++) begin
                check($sformatf("rdata%0d", i), rd(i), exp_rd[i]);
`ifdef REGFILE_PARITY_EN
                check($sformatf("par_err%0d", i), XLEN'(par_err[i]), XLEN'(exp_par[i]));
`endif
            end
        end
    end

    // Counts negedges with busy high starting at the current one; bounded.
    task automatic count_busy(input string name);
        int c = 0;
        while (busy === 1'b1 && c < 200) begin
            c++;
            @(negedge clk);
        end
        check(name, XLEN'(c), XLEN'(NREG - 1));
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        reset = 1'b0; clear_req = 1'b0; we = 1'b0;
        waddr = '0; wdata = '0; raddr = '0;

        // Reset held for three edges.
        @(posedge clk);
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", XLEN'(busy), XLEN'(1'b1));
        check("rst_wr_drop", XLEN'(wr_drop), '0);
        check("rst_rdata0", rd(0), '0);
        check("rst_rdata1", rd(1), '0);

        // Release: busy for NREG-1 cycles while reading x5.
        set_rd(0, 5);
        reset = 1'b1;
        count_busy("busy_len_after_reset");
        @(negedge clk);
        check("x5_after_clear", rd(0), '0);

        // Basic write then dual read of x7.
        we = 1'b1; waddr = 5'd7; wdata = 64'hDEADBEEF_CAFEF00D;
        @(negedge clk);
        we = 1'b0; set_rd(0, 7); set_rd(1, 7);
        @(negedge clk);
        check("x7_port0", rd(0), 64'hDEADBEEF_CAFEF00D);
        check("x7_port1", rd(1), 64'hDEADBEEF_CAFEF00D);

        // Write-first bypass on port 0, x0 on port 1.
        we = 1'b1; waddr = 5'd9; wdata = 64'h1234; set_rd(0, 9); set_rd(1, 0);
        @(negedge clk);
        check("bypass_port0", rd(0), 64'h1234);
        check("bypass_x0_port1", rd(1), '0);
        we = 1'b0; set_rd(1, 9);
        @(negedge clk);
        check("x9_stored_port1", rd(1), 64'h1234);

        // Write to x0 is ignored without a drop pulse.
        we = 1'b1; waddr = 5'd0; wdata = 64'hFFFF; set_rd(0, 0);
        @(negedge clk);
        check("x0_write_no_drop", XLEN'(wr_drop), '0);
        we = 1'b0;
        @(negedge clk);
        check("x0_reads_zero", rd(0), '0);

        // Boundary entries x1 and x31.
        we = 1'b1; waddr = 5'd31; wdata = 64'hA5A5_5A5A_0F0F_F0F0;
        @(negedge clk);
        waddr = 5'd1; wdata = 64'h1;
        @(negedge clk);
        we = 1'b0; set_rd(0, 31); set_rd(1, 1);
        @(negedge clk);
        check("x31_read", rd(0), 64'hA5A5_5A5A_0F0F_F0F0);
        check("x1_read", rd(1), 64'h1);

        // Write together with clear_req is dropped; then a full clear.
        clear_req = 1'b1; we = 1'b1; waddr = 5'd3; wdata = 64'h3333;
        @(negedge clk);
        clear_req = 1'b0; we = 1'b0;
        check("drop_with_clear_req", XLEN'(wr_drop), XLEN'(1'b1));
        check("busy_on_clear_req", XLEN'(busy), XLEN'(1'b1));
        count_busy("busy_len_after_clear_req");
        set_rd(0, 3); set_rd(1, 7);
        @(negedge clk);
        check("x3_after_clear", rd(0), '0);
        check("x7_after_clear", rd(1), '0);

        // Write during CLEAR is dropped; clear_req mid-clear restarts the count.
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0; we = 1'b1; waddr = 5'd2; wdata = 64'h2;
        @(negedge clk);
        we = 1'b0;
        check("drop_in_clear", XLEN'(wr_drop), XLEN'(1'b1));
        repeat (5) @(negedge clk);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        count_busy("busy_len_after_restart");

        // Reset asserted mid-clear restarts the sequence after release.
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        count_busy("busy_len_after_mid_reset");

        // Fill every entry, reading neighbours concurrently, then read back pairs.
        for (int r = 1; r < NREG; r++) begin
            we = 1'b1; waddr = AW'(r); wdata = XLEN'(r) * 64'h0101_0101_0101_0101;
            set_rd(0, r); set_rd(1, r - 1);
            @(negedge clk);
        end
        we = 1'b0;
        for (int r = 1; r < NREG; r++) begin
            set_rd(0, r); set_rd(1, NREG - r);
            @(negedge clk);
        end
        set_rd(0, 4); set_rd(1, 30);
        @(negedge clk);
        check("fill_x4", rd(0), 64'h0404_0404_0404_0404);
        check("fill_x30", rd(1), 64'h1E1E_1E1E_1E1E_1E1E);

`ifdef REGFILE_PARITY_EN
        // Corrupt one stored bit of x4 behind the parity bit's back.
        dut.mem_q[4][0] = ~dut.mem_q[4][0];
        m_reg[4][0] = ~m_reg[4][0];
        m_bad[4] = 1'b1;
        set_rd(0, 4);
        @(negedge clk);
        check("par_err_x4", XLEN'(par_err[0]), XLEN'(1'b1));
        check("par_x4_data", rd(0), 64'h0404_0404_0404_0405);
        set_rd(0, 5);
        @(negedge clk);
        check("par_ok_x5", XLEN'(par_err[0]), '0);
`endif

        @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
